// File: rtl/wave_gen_pkg.sv
// Shared types for the waveform selection path: offer FSM states, index type and
// the default number of selectable settings, also used by the wave generator.
package wave_gen_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam int unsigned WAVE_NUM_SEL = 4;

  typedef logic [1:0] sel_idx_t;

endpackage

// File: rtl/wave_sel_ctrl.sv
// Button-driven setting index with a valid/ready offer to the wave generator.
// Define WAVE_SEL_WRAP_EN to wrap the index at its ends; otherwise it saturates.
module wave_sel_ctrl
  import wave_gen_pkg::*;
#(
  parameter int NUM_SEL = WAVE_NUM_SEL,
  parameter int RST_IDX = 0,
  localparam int IDX_W  = $clog2(NUM_SEL)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_up_n,
  input  logic             i_dn_n,
  output logic [IDX_W-1:0] o_sel_idx,
  output logic             o_sel_valid,
  output logic [IDX_W-1:0] o_sel_data,
  input  logic             i_sel_ready,
  output logic             o_busy
);

  localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(NUM_SEL - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = '0;
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W-1:0] INIT_IDX = IDX_W'(RST_IDX);

  state_e           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [IDX_W-1:0] data, data_n;
  logic             dirty, dirty_n;
  logic             up, dn, evt;

  // Simultaneous UP and DOWN strobes cancel each other.
  assign up = !i_up_n && i_dn_n;
  assign dn = !i_dn_n && i_up_n;

  always_comb begin
    idx_n = idx;
    evt   = 1'b0;
`ifdef WAVE_SEL_WRAP_EN
    if (up) begin
      idx_n = (idx == MAX_IDX) ? ZERO_IDX : idx + ONE_IDX;
      evt   = 1'b1;
    end else if (dn) begin
      idx_n = (idx == ZERO_IDX) ? MAX_IDX : idx - ONE_IDX;
      evt   = 1'b1;
    end
`else
    if (up && (idx != MAX_IDX)) begin
      idx_n = idx + ONE_IDX;
      evt   = 1'b1;
    end else if (dn && (idx != ZERO_IDX)) begin
      idx_n = idx - ONE_IDX;
      evt   = 1'b1;
    end
`endif
  end

  always_comb begin
    state_n = state;
    data_n  = data;
    dirty_n = dirty;
    unique case (state)
      IDLE: begin
        if (evt) begin
          state_n = OFFER;
          data_n  = idx_n;
        end
      end
      OFFER: begin
        if (i_sel_ready) begin
          // Presses collected during a stall collapse into one re-offer of the newest index.
          if (dirty || evt) begin
            data_n  = idx_n;
            dirty_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else if (evt) begin
          dirty_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx   <= INIT_IDX;
      data  <= INIT_IDX;
      dirty <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      data  <= data_n;
      dirty <= dirty_n;
    end
  end

  assign o_sel_idx   = idx;
  assign o_sel_data  = data;
  assign o_sel_valid = (state == OFFER);
  assign o_busy      = (state == OFFER) | dirty;

endmodule

// File: tb/tb_wave_sel_ctrl.sv
// Directed bench for wave_sel_ctrl (NUM_SEL=4, RST_IDX=0); boundary rows follow WAVE_SEL_WRAP_EN.
module tb_wave_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_n = 1'b1;
  logic       dn_n = 1'b1;
  logic       rdy = 1'b1;
  logic [1:0] sel_idx;
  logic       sel_valid;
  logic [1:0] sel_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic       up_n;
    logic       dn_n;
    logic       rdy;
    logic [1:0] e_idx;
    logic       e_vld;
    logic [1:0] e_data;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  wave_sel_ctrl #(.NUM_SEL(4), .RST_IDX(0)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_up_n     (up_n),
    .i_dn_n     (dn_n),
    .o_sel_idx  (sel_idx),
    .o_sel_valid(sel_valid),
    .o_sel_data (sel_data),
    .i_sel_ready(rdy),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic u, input logic d, input logic rd,
                              input logic [1:0] ei, input logic ev, input logic [1:0] ed,
                              input logic eb);
    vec_t v;
    v.rst_n = r; v.up_n = u; v.dn_n = d; v.rdy = rd;
    v.e_idx = ei; v.e_vld = ev; v.e_data = ed; v.e_busy = eb;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_check(input string tag, input logic r, input logic u, input logic d,
                            input logic rd, input logic [1:0] ei, input logic ev,
                            input logic [1:0] ed, input logic eb);
    rst_n = r; up_n = u; dn_n = d; rdy = rd;
    @(posedge clk);
    #1;
    chk({tag, ".idx"},   int'(sel_idx),   int'(ei));
    chk({tag, ".valid"}, int'(sel_valid), int'(ev));
    chk({tag, ".data"},  int'(sel_data),  int'(ed));
    chk({tag, ".busy"},  int'(busy),      int'(eb));
  endtask

  initial begin
    // rst up dn rdy | idx vld data busy  (outputs after the edge)
    add(0, 1, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 1);
    add(1, 1, 1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 1, 1, 0, 1, 0);
    add(1, 0, 1, 1, 2, 1, 2, 1);
    add(1, 1, 1, 1, 2, 0, 2, 0);
    add(1, 1, 1, 1, 2, 0, 2, 0);
    add(1, 1, 1, 1, 2, 0, 2, 0);
    add(1, 0, 1, 1, 3, 1, 3, 1);
    add(1, 1, 1, 1, 3, 0, 3, 0);
`ifdef WAVE_SEL_WRAP_EN
    add(1, 0, 1, 1, 0, 1, 0, 1);
    add(1, 1, 1, 1, 0, 0, 0, 0);
`else
    add(1, 0, 1, 1, 3, 0, 3, 0);
    add(1, 1, 1, 1, 3, 0, 3, 0);
`endif
    add(0, 1, 1, 1, 0, 0, 0, 0);
`ifdef WAVE_SEL_WRAP_EN
    add(1, 1, 0, 1, 3, 1, 3, 1);
    add(1, 1, 1, 1, 3, 0, 3, 0);
`else
    add(1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0, 0);
`endif
    add(0, 1, 1, 1, 0, 0, 0, 0);
    // stalled offer collecting three presses
    add(1, 0, 1, 0, 1, 1, 1, 1);
    add(1, 0, 1, 0, 2, 1, 1, 1);
    add(1, 0, 1, 0, 3, 1, 1, 1);
    add(1, 1, 1, 0, 3, 1, 1, 1);
    add(1, 1, 1, 1, 3, 1, 3, 1);
    add(1, 1, 1, 1, 3, 0, 3, 0);
    // both strobes low cancel
    add(1, 0, 0, 1, 3, 0, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0);
    // press coinciding with a transfer
    add(1, 0, 1, 1, 1, 1, 1, 1);
    add(1, 0, 1, 1, 2, 1, 2, 1);
    add(1, 1, 1, 1, 2, 0, 2, 0);
    add(1, 1, 0, 1, 1, 1, 1, 1);
    add(1, 1, 1, 1, 1, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step_check($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].up_n, vecs[i].dn_n,
                 vecs[i].rdy, vecs[i].e_idx, vecs[i].e_vld, vecs[i].e_data, vecs[i].e_busy);
    end

    // Reset while an offer is stalled, with a press in the same cycle.
    step_check("rst_offer.a", 1, 0, 1, 0, 2, 1, 2, 1);
    step_check("rst_offer.b", 1, 0, 1, 0, 3, 1, 2, 1);
    step_check("rst_offer.c", 0, 0, 1, 0, 0, 0, 0, 0);
    step_check("rst_offer.d", 1, 1, 1, 1, 0, 0, 0, 0);

    // Ready is ignored while no offer is pending.
    step_check("idle_rdy.a", 1, 1, 1, 1, 0, 0, 0, 0);
    step_check("idle_rdy.b", 1, 1, 1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
